// File: rtl/stack_pkg.sv
// Shared opcode and FSM-state definitions for the stack unit.
// No logic, no latency.
// No flow control of its own.
package stack_pkg;

  // Operation codes carried on the op port
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_PEEK = 3'd5,
    OP_CLR  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  // Control FSM states; only ST_IDLE accepts a new operation
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALL2 = 2'd1,
    ST_RD1   = 2'd2,
    ST_RET2  = 2'd3
  } state_e;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: WIDTH x DEPTH array, one synchronous write port, one synchronous read port.
// Read data appears the cycle after the address is presented; writes land on the same edge.
// No backpressure; the caller sequences accesses.
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read port; contents survive reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stack_unit.sv
// Hardware stack with PUSH/POP/PEEK, two-word CALL/RET frames, CLR and a sticky fault flag.
// PUSH/CLR 1 cycle; POP/PEEK data 1 cycle after accept; CALL 2 cycles; RET data 2 cycles after accept.
// op_ready is low in CALL2/RD1/RET2; requests seen while not ready are dropped, not queued.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             rvalid,
  output logic [AW:0]      sp,
  output logic             full,
  output logic             empty,
  output logic             fault
);

  localparam logic [AW:0]   SP_ONE      = (AW+1)'(1);
  localparam logic [AW:0]   SP_TWO      = (AW+1)'(2);
  localparam logic [AW:0]   SP_FULL     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   SP_CALL_MAX = (AW+1)'(DEPTH - 2);
  localparam logic [AW-1:0] ADDR_ONE    = AW'(1);

  state_e           state_q;
  logic [AW:0]      sp_q;
  logic             fault_q;
  logic             rvalid_q;
  logic             zero_q;      // current read result is a faulted one: force zeros
  logic [WIDTH-1:0] rdata0_q;    // rdata0 held between pulses
  logic [WIDTH-1:0] rdata1_q;
  logic [WIDTH-1:0] wdata1_q;    // CALL return address, written in CALL2

  op_e              op_c;
  logic             full_w;
  logic             empty_w;
  logic             call_ok;
  logic             ret_ok;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [AW-1:0]    mem_raddr;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] rd0_live;

  assign op_c    = op_e'(op);
  assign full_w  = (sp_q == SP_FULL);
  assign empty_w = (sp_q == '0);
  assign call_ok = (sp_q <= SP_CALL_MAX);
  assign ret_ok  = (sp_q >= SP_TWO);

  // RAM write port: first word in IDLE, second CALL word in CALL2; a reset cycle never writes
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = sp_q[AW-1:0];
    mem_wdata = wdata0;
    if (!reset) begin
      if (state_q == ST_CALL2) begin
        mem_we    = 1'b1;
        mem_waddr = sp_q[AW-1:0] + ADDR_ONE;
        mem_wdata = wdata1_q;
      end else if (state_q == ST_IDLE && op_valid) begin
        if ((op_c == OP_PUSH && !full_w) || (op_c == OP_CALL && call_ok)) begin
          mem_we = 1'b1;
        end
      end
    end
  end

  // Read address: top word from IDLE; in RET2 sp already points at the frame base
  assign mem_raddr = (state_q == ST_RET2) ? sp_q[AW-1:0] : (sp_q[AW-1:0] - ADDR_ONE);

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  // Control FSM: decodes accepted ops, moves sp, tracks fault and the read pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sp_q     <= '0;
      fault_q  <= 1'b0;
      rvalid_q <= 1'b0;
      zero_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (rvalid_q) begin
        rdata0_q <= rd0_live;
      end
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            case (op_c)
              OP_PUSH: begin
                if (full_w) fault_q <= 1'b1;
                else        sp_q    <= sp_q + SP_ONE;
              end
              OP_CALL: begin
                if (!call_ok) begin
                  fault_q <= 1'b1;
                end else begin
                  wdata1_q <= wdata1;
                  state_q  <= ST_CALL2;
                end
              end
              OP_POP, OP_PEEK: begin
                state_q  <= ST_RD1;
                rvalid_q <= 1'b1;
                rdata1_q <= '0;
                zero_q   <= empty_w;
                if (empty_w)              fault_q <= 1'b1;
                else if (op_c == OP_POP)  sp_q    <= sp_q - SP_ONE;
              end
              OP_RET: begin
                state_q <= ST_RET2;
                zero_q  <= !ret_ok;
                if (!ret_ok) fault_q <= 1'b1;
                else         sp_q    <= sp_q - SP_TWO;
              end
              OP_CLR: begin
                sp_q    <= '0;
                fault_q <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_CALL2: begin
          sp_q    <= sp_q + SP_TWO;
          state_q <= ST_IDLE;
        end
        ST_RD1: begin
          state_q <= ST_IDLE;
        end
        ST_RET2: begin
          state_q  <= ST_IDLE;
          rvalid_q <= 1'b1;
          rdata1_q <= zero_q ? '0 : mem_rdata;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd0_live = zero_q ? '0 : mem_rdata;

  assign op_ready = (state_q == ST_IDLE);
  assign rvalid   = rvalid_q & ~reset;
  assign rdata0   = rvalid_q ? rd0_live : rdata0_q;
  assign rdata1   = rdata1_q;
  assign sp       = sp_q;
  assign full     = full_w;
  assign empty    = empty_w;
  assign fault    = fault_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit (DEPTH=4) with a stack-level reference model checked every cycle.
module tb_stack_unit;

  localparam int W = 16;
  localparam int D = 4;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_PUSH = 3'd1;
  localparam logic [2:0] C_POP  = 3'd2;
  localparam logic [2:0] C_CALL = 3'd3;
  localparam logic [2:0] C_RET  = 3'd4;
  localparam logic [2:0] C_PEEK = 3'd5;
  localparam logic [2:0] C_CLR  = 3'd6;
  localparam logic [2:0] C_RSVD = 3'd7;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] wdata0 = '0;
  logic [W-1:0] wdata1 = '0;
  logic [W-1:0] rdata0;
  logic [W-1:0] rdata1;
  logic         rvalid;
  logic [2:0]   sp;
  logic         full;
  logic         empty;
  logic         fault;

  int n_cmp = 0;
  int n_err = 0;
  bit m_init = 1'b0;

  stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op       (op),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .rvalid   (rvalid),
    .sp       (sp),
    .full     (full),
    .empty    (empty),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain array stack plus a countdown of busy cycles
  logic [W-1:0] m_mem [D];
  int           m_sp = 0;
  bit           m_fault = 0;
  int           m_phase = 0;   // 0 idle, 1 second CALL word pending, 2 read cycle, 3 RET result pending
  bit           m_rvalid = 0;
  logic [W-1:0] m_rd0 = '0, m_rd1 = '0;
  logic [W-1:0] p_r0, p_r1, p_w;
  int           p_idx;

  always @(posedge clk) begin
    if (reset) begin
      m_sp = 0; m_fault = 0; m_phase = 0; m_rvalid = 0; m_rd0 = '0; m_rd1 = '0;
    end else begin
      m_rvalid = 0;
      case (m_phase)
        1: begin m_mem[p_idx] = p_w; m_sp += 2; m_phase = 0; end
        2: m_phase = 0;
        3: begin m_rvalid = 1; m_rd0 = p_r0; m_rd1 = p_r1; m_phase = 0; end
        default: if (op_valid) begin
          case (op)
            C_PUSH: if (m_sp == D) m_fault = 1;
                    else begin m_mem[m_sp] = wdata0; m_sp++; end
            C_CALL: if (m_sp > D - 2) m_fault = 1;
                    else begin m_mem[m_sp] = wdata0; p_idx = m_sp + 1; p_w = wdata1; m_phase = 1; end
            C_POP, C_PEEK: begin
              m_rvalid = 1; m_rd1 = '0; m_phase = 2;
              if (m_sp == 0) begin m_fault = 1; m_rd0 = '0; end
              else begin
                m_rd0 = m_mem[m_sp-1];
                if (op == C_POP) m_sp--;
              end
            end
            C_RET: begin
              m_phase = 3;
              if (m_sp < 2) begin m_fault = 1; p_r0 = '0; p_r1 = '0; end
              else begin p_r1 = m_mem[m_sp-1]; p_r0 = m_mem[m_sp-2]; m_sp -= 2; end
            end
            C_CLR: begin m_sp = 0; m_fault = 0; end
            default: ;
          endcase
        end
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_init && !reset) begin
      chk("sp", 32'(sp), 32'(m_sp));
      chk("full", 32'(full), 32'(m_sp == D));
      chk("empty", 32'(empty), 32'(m_sp == 0));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("op_ready", 32'(op_ready), 32'(m_phase == 0));
      chk("rvalid", 32'(rvalid), 32'(m_rvalid));
      chk("rdata0", 32'(rdata0), 32'(m_rd0));
      chk("rdata1", 32'(rdata1), 32'(m_rd1));
    end
  end

  // Present one op when the unit is ready; it transfers on the following edge
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL op_ready timeout: got 0 expected 1 at %0t", $time);
    end
    #1;
    op_valid = 1'b1; op = o; wdata0 = a; wdata1 = b;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_init = 1'b1;
    @(negedge clk);
    chk("rst_sp", 32'(sp), 0);
    chk("rst_ready", 32'(op_ready), 1);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata0", 32'(rdata0), 0);
    chk("rst_fault", 32'(fault), 0);

    // push/pop ordering
    do_op(C_PUSH, 16'h1111, 16'h0); @(negedge clk); chk("p1_sp", 32'(sp), 1);
    do_op(C_PUSH, 16'h2222, 16'h0); @(negedge clk); chk("p2_sp", 32'(sp), 2);
    do_op(C_POP, 16'h0, 16'h0); @(negedge clk);
    chk("pop1_rv", 32'(rvalid), 1); chk("pop1_d", 32'(rdata0), 32'h2222); chk("pop1_sp", 32'(sp), 1);
    do_op(C_POP, 16'h0, 16'h0); @(negedge clk);
    chk("pop2_d", 32'(rdata0), 32'h1111); chk("pop2_sp", 32'(sp), 0); chk("pop2_fault", 32'(fault), 0);

    // call/ret frame
    do_op(C_CALL, 16'h0040, 16'h0123); @(negedge clk);
    chk("call_busy", 32'(op_ready), 0); chk("call_sp_t1", 32'(sp), 0);
    @(negedge clk); chk("call_sp_t2", 32'(sp), 2); chk("call_ready", 32'(op_ready), 1);
    do_op(C_RET, 16'h0, 16'h0); @(negedge clk);
    chk("ret_t1_rv", 32'(rvalid), 0); chk("ret_t1_sp", 32'(sp), 0);
    @(negedge clk);
    chk("ret_rv", 32'(rvalid), 1); chk("ret_d1", 32'(rdata1), 32'h0123); chk("ret_d0", 32'(rdata0), 32'h0040);

    // underflow cases
    do_op(C_POP, 16'h0, 16'h0); @(negedge clk);
    chk("upop_rv", 32'(rvalid), 1); chk("upop_d", 32'(rdata0), 0); chk("upop_fault", 32'(fault), 1);
    do_op(C_CLR, 16'h0, 16'h0);
    do_op(C_PUSH, 16'h0007, 16'h0);
    do_op(C_RET, 16'h0, 16'h0); @(negedge clk);
    chk("uret_sp", 32'(sp), 1); chk("uret_fault", 32'(fault), 1);
    @(negedge clk);
    chk("uret_rv", 32'(rvalid), 1); chk("uret_d0", 32'(rdata0), 0); chk("uret_d1", 32'(rdata1), 0);
    do_op(C_CLR, 16'h0, 16'h0);

    // overflow at capacity
    for (int i = 1; i <= 4; i++) do_op(C_PUSH, 16'hA000 + 16'(i), 16'h0);
    do_op(C_PUSH, 16'hBEEF, 16'h0); @(negedge clk);
    chk("ovf_full", 32'(full), 1); chk("ovf_sp", 32'(sp), 4); chk("ovf_fault", 32'(fault), 1);
    do_op(C_POP, 16'h0, 16'h0); @(negedge clk); chk("ovf_pop", 32'(rdata0), 32'hA004);
    do_op(C_CLR, 16'h0, 16'h0); @(negedge clk);
    chk("clr_sp", 32'(sp), 0); chk("clr_fault", 32'(fault), 0);

    // CALL filling the last slot, then CALL with too little room
    do_op(C_PUSH, 16'h0B01, 16'h0);
    do_op(C_PUSH, 16'h0B02, 16'h0);
    do_op(C_CALL, 16'h0C01, 16'h0C02); @(negedge clk); @(negedge clk);
    chk("cfull_sp", 32'(sp), 4); chk("cfull_full", 32'(full), 1); chk("cfull_fault", 32'(fault), 0);
    do_op(C_RET, 16'h0, 16'h0); @(negedge clk); @(negedge clk);
    chk("cret_d0", 32'(rdata0), 32'h0C01); chk("cret_d1", 32'(rdata1), 32'h0C02);
    do_op(C_PUSH, 16'h0B03, 16'h0);
    do_op(C_CALL, 16'h0D01, 16'h0D02); @(negedge clk);
    chk("covf_sp", 32'(sp), 3); chk("covf_fault", 32'(fault), 1); chk("covf_ready", 32'(op_ready), 1);
    do_op(C_CLR, 16'h0, 16'h0);

    // PEEK, NOP and reserved opcode
    do_op(C_PUSH, 16'h0055, 16'h0);
    do_op(C_PEEK, 16'h0, 16'h0); @(negedge clk);
    chk("peek_d", 32'(rdata0), 32'h0055); chk("peek_sp", 32'(sp), 1); chk("peek_d1", 32'(rdata1), 0);
    do_op(C_RSVD, 16'hFFFF, 16'hFFFF);
    do_op(C_NOP, 16'hFFFF, 16'hFFFF); @(negedge clk);
    chk("nop_sp", 32'(sp), 1); chk("nop_fault", 32'(fault), 0);
    do_op(C_CLR, 16'h0, 16'h0);

    // reset in the middle of CALL2
    do_op(C_CALL, 16'h0AAA, 16'h0BBB);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstc_rv", 32'(rvalid), 0); chk("rstc_sp", 32'(sp), 0);
    end
    do_op(C_PUSH, 16'h0005, 16'h0);
    do_op(C_POP, 16'h0, 16'h0); @(negedge clk);
    chk("rstc_pop", 32'(rdata0), 32'h0005);

    // request held during RD1 must land exactly once
    do_op(C_PUSH, 16'h0011, 16'h0);
    do_op(C_POP, 16'h0, 16'h0);
    op_valid = 1'b1; op = C_PUSH; wdata0 = 16'h0099;
    @(negedge clk); chk("hold_busy", 32'(op_ready), 0);
    @(posedge clk); @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk); chk("hold_sp", 32'(sp), 1);
    do_op(C_POP, 16'h0, 16'h0); @(negedge clk);
    chk("hold_pop", 32'(rdata0), 32'h0099); chk("hold_sp0", 32'(sp), 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 1024, stack capacity in words; power of two, >= 4.
REQ-003 Derived constant AW = clog2(DEPTH); sp is AW+1 bits so it can represent DEPTH (full).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 op_valid  in  1  operation request.
REQ-007 op_ready  out  1  unit can accept an operation.
REQ-008 op  in  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 PEEK, 6 CLR, 7 reserved.
REQ-009 wdata0  in  WIDTH  PUSH word; CALL first word (frame base).
REQ-010 wdata1  in  WIDTH  CALL second word (return address).
REQ-011 rdata0  out  WIDTH  POP/PEEK word; RET frame base.
REQ-012 rdata1  out  WIDTH  RET return address; 0 for other ops.
REQ-013 rvalid  out  1  one-cycle pulse; rdata0/rdata1 valid.
REQ-014 sp  out  AW+1  current stack pointer (number of words stored).
REQ-015 full / empty  out  1 each  sp==DEPTH / sp==0.
REQ-016 fault  out  1  sticky overflow/underflow indicator.

Function
REQ-017 Operation SHALL transfer only on a cycle with op_valid && op_ready; op_ready SHALL equal (state==IDLE); requests while op_ready is low are ignored, not queued.
REQ-018 States: IDLE, CALL2, RD1, RET2; only IDLE accepts operations.
REQ-019 PUSH at T: mem[sp]<=wdata0, sp+1 visible at T+1; state stays IDLE.
REQ-020 CALL at T: mem[sp]<=wdata0; T+1 (CALL2) mem[sp+1]<=latched wdata1; sp+2 visible at T+2; IDLE at T+2.
REQ-021 POP at T: read mem[sp-1], sp-1 visible at T+1, state RD1; T+1 rvalid=1, rdata0=word, back to IDLE.
REQ-022 PEEK: as POP but sp unchanged.
REQ-023 RET at T: read mem[sp-1] (return address), sp-2 visible at T+1, state RET2; T+1 read mem[sp_old-2]; T+2 rvalid=1, rdata1=return address, rdata0=frame base, IDLE.
REQ-024 CLR: sp<=0, fault<=0 at T+1; memory contents untouched.
REQ-025 NOP and opcode 7: no state change, no fault.
REQ-026 PUSH when full, or CALL when sp>DEPTH-2: no memory write, sp unchanged, fault<=1, no CALL2 cycle.
REQ-027 POP/PEEK when empty, or RET when sp<2: sp unchanged, fault<=1; rvalid still pulses at the normal latency with rdata0=rdata1=0.
REQ-028 fault SHALL stay set until CLR or reset; operations are still accepted while fault=1.
REQ-029 rdata0/rdata1 SHALL hold their last values between rvalid pulses.
REQ-030 CALL writing index DEPTH-1 SHALL succeed when sp==DEPTH-2 and result in full=1.

Reset
REQ-031 On reset: state=IDLE, sp=0, fault=0, rvalid=0, rdata0=rdata1=0, op_ready=1 the cycle after.
REQ-032 Reset during CALL2/RD1/RET2 SHALL abort: no memory write in the reset cycle, no rvalid pulse.
REQ-033 Memory array is not cleared by reset.

Structure
REQ-034 Shared package stack_pkg SHALL hold opcode constants and the state encoding.
REQ-035 Sub-module stack_ram (WIDTH x DEPTH, one synchronous write port, one synchronous read port) SHALL hold the storage.

Verification
REQ-036 PUSH 0x1111, 0x2222, POP, POP -> rvalid with 0x2222 then 0x1111; sp 1,2,1,0; fault=0.
REQ-037 CALL wdata0=0x0040 wdata1=0x0123, then RET -> op_ready low one cycle after CALL; RET rvalid at T+2 with rdata1=0x0123, rdata0=0x0040; sp 0->2->0.
REQ-038 DEPTH=4: 4 PUSHes then PUSH 0xBEEF -> full=1, sp=4, fault=1, POP returns 4th pushed word; CLR -> sp=0, fault=0.
REQ-039 POP on empty -> rvalid pulse, rdata0=0, sp=0, fault=1; RET with sp=1 -> fault=1, sp=1.
REQ-040 reset asserted during CALL2 -> sp=0, no rvalid, subsequent PUSH 0x0005/POP returns 0x0005.
REQ-041 op_valid held with PUSH during RD1 -> not accepted until IDLE, exactly one word pushed.
